wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile.sv | 74 +++++++
 tb/tb_wb_regfile.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Writeback-stage register file: 32 x WIDTH registers, R0 hardwired to zero,
// write-through bypass on both read ports and a count of committed writes.
module wb_regfile #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             Reset_L,
  input  logic             MemToReg_MEM_WB,
  input  logic             RegWrite_MEM_WB,
  input  logic [4:0]       RW_MEM_WB,
  input  logic [WIDTH-1:0] DataOut_MEM_WB,
  input  logic [WIDTH-1:0] ALU_OUT_MEM_WB,
  input  logic [4:0]       RA,
  input  logic [4:0]       RB,
  output logic [WIDTH-1:0] BusA,
  output logic [WIDTH-1:0] BusB,
  output logic [WIDTH-1:0] BusW,
  output logic [31:0]      WB_Count
);

  logic [WIDTH-1:0] regs_q [32];
  logic [WIDTH-1:0] regs_d [32];
  logic [31:0]      wb_count_q;
  logic [31:0]      wb_count_d;
  logic             commit;

  always_comb begin
    BusW = MemToReg_MEM_WB ? DataOut_MEM_WB : ALU_OUT_MEM_WB;
  end

  // Index-0 writes are neither stored nor counted.
  assign commit = RegWrite_MEM_WB && (RW_MEM_WB != 5'd0);

  always_comb begin
    regs_d     = regs_q;
    wb_count_d = wb_count_q;
    if (commit) begin
      regs_d[RW_MEM_WB] = BusW;
      wb_count_d        = wb_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge Reset_L) begin
    if (!Reset_L) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      wb_count_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wb_count_q <= wb_count_d;
    end
  end

  // Bypass keys off commit, so a disabled or index-0 write never forwards.
  always_comb begin
    BusA = '0;
    if (RA != 5'd0) begin
      if (commit && (RW_MEM_WB == RA)) BusA = BusW;
      else                             BusA = regs_q[RA];
    end
  end

  always_comb begin
    BusB = '0;
    if (RB != 5'd0) begin
      if (commit && (RW_MEM_WB == RB)) BusB = BusW;
      else                             BusB = regs_q[RB];
    end
  end

  assign WB_Count = wb_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized bench for wb_regfile against an array-based reference model,
// with directed cases for bypass, R0, disabled writes, count wrap and reset.
module tb_wb_regfile;

  logic        clk;
  logic        Reset_L;
  logic        MemToReg_MEM_WB;
  logic        RegWrite_MEM_WB;
  logic [4:0]  RW_MEM_WB;
  logic [31:0] DataOut_MEM_WB;
  logic [31:0] ALU_OUT_MEM_WB;
  logic [4:0]  RA;
  logic [4:0]  RB;
  logic [31:0] BusA;
  logic [31:0] BusB;
  logic [31:0] BusW;
  logic [31:0] WB_Count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] ref_r [32];
  logic [31:0] ref_count;

  wb_regfile #(.WIDTH(32)) dut (
    .clk             (clk),
    .Reset_L         (Reset_L),
    .MemToReg_MEM_WB (MemToReg_MEM_WB),
    .RegWrite_MEM_WB (RegWrite_MEM_WB),
    .RW_MEM_WB       (RW_MEM_WB),
    .DataOut_MEM_WB  (DataOut_MEM_WB),
    .ALU_OUT_MEM_WB  (ALU_OUT_MEM_WB),
    .RA              (RA),
    .RB              (RB),
    .BusA            (BusA),
    .BusB            (BusB),
    .BusW            (BusW),
    .WB_Count        (WB_Count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model
  function automatic logic [31:0] ref_busw();
    return MemToReg_MEM_WB ? DataOut_MEM_WB : ALU_OUT_MEM_WB;
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (RegWrite_MEM_WB && RW_MEM_WB == idx) return ref_busw();
    return ref_r[idx];
  endfunction

  task automatic ref_reset();
    for (int i = 0; i < 32; i++) ref_r[i] = 32'h0;
    ref_count = 32'h0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".busw"}, BusW, ref_busw());
    check({tag, ".busa"}, BusA, ref_read(RA));
    check({tag, ".busb"}, BusB, ref_read(RB));
    check({tag, ".count"}, WB_Count, ref_count);
  endtask

  // driver: inputs change on the falling edge, checks 1ns later, model
  // commits on the following rising edge
  task automatic drive(input string tag, input logic we, input logic m2r,
                       input logic [4:0] rw, input logic [31:0] dout,
                       input logic [31:0] alu, input logic [4:0] ra,
                       input logic [4:0] rb);
    logic [31:0] w;
    @(negedge clk);
    RegWrite_MEM_WB = we;
    MemToReg_MEM_WB = m2r;
    RW_MEM_WB       = rw;
    DataOut_MEM_WB  = dout;
    ALU_OUT_MEM_WB  = alu;
    RA              = ra;
    RB              = rb;
    #1;
    check_outputs(tag);
    w = ref_busw();
    @(posedge clk);
    if (Reset_L && we && rw != 5'd0) begin
      ref_r[rw] = w;
      ref_count = ref_count + 32'd1;
    end
  endtask

  initial begin
    logic [4:0] rw;
    logic [4:0] ra;
    logic [4:0] rb;
    logic       we;

    Reset_L = 1'b0;
    MemToReg_MEM_WB = 1'b0;
    RegWrite_MEM_WB = 1'b0;
    RW_MEM_WB = 5'd0;
    DataOut_MEM_WB = 32'h0;
    ALU_OUT_MEM_WB = 32'h0;
    RA = 5'd1;
    RB = 5'd31;
    ref_reset();
    #2;
    check_outputs("reset");
    @(negedge clk);
    Reset_L = 1'b1;

    // ALU writeback, then read back with writes disabled
    drive("alu_wr", 1'b1, 1'b0, 5'd5, 32'h0, 32'h0000_1234, 5'd0, 5'd0);
    drive("alu_rd", 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd5);
    check("alu_rd.r5", BusA, 32'h0000_1234);
    check("alu_rd.cnt1", WB_Count, 32'd1);

    // memory writeback bypassed to both ports in the same cycle
    drive("byp_wr", 1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF, 32'h0, 5'd7, 5'd7);
    drive("byp_rd", 1'b0, 1'b0, 5'd7, 32'h0, 32'h0, 5'd7, 5'd7);
    check("byp_rd.r7", BusB, 32'hDEAD_BEEF);

    // writes to R0 are dropped and not counted
    drive("r0_wr", 1'b1, 1'b0, 5'd0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    drive("r0_rd", 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
    check("r0_rd.cnt", WB_Count, 32'd2);

    // matching index with write disabled must not bypass
    drive("nob_wr", 1'b1, 1'b0, 5'd3, 32'h0, 32'hA5A5_A5A5, 5'd0, 5'd0);
    drive("nob_rd", 1'b0, 1'b0, 5'd3, 32'h0, 32'h1111_1111, 5'd3, 5'd3);
    check("nob_rd.r3", BusA, 32'hA5A5_A5A5);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      we = ($urandom_range(0, 3) != 0);
      rw = 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom_range(0, 31));
      drive("rand", we, 1'($urandom_range(0, 1)), rw, $urandom, $urandom, ra, rb);
    end

    // counter wrap: preload via backdoor, then one commit
    @(negedge clk);
    RegWrite_MEM_WB = 1'b0;
    force dut.wb_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.wb_count_q;
    ref_count = 32'hFFFF_FFFF;
    drive("wrap_wr", 1'b1, 1'b0, 5'd9, 32'h0, 32'h0000_0099, 5'd1, 5'd9);
    drive("wrap_rd", 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd1);
    check("wrap.count0", WB_Count, 32'h0);

    // populate all registers nonzero, then reset mid-cycle with a write pending
    for (int i = 1; i < 32; i++) begin
      drive("fill", 1'b1, 1'($urandom_range(0, 1)), 5'(i), $urandom | 32'h1,
            $urandom | 32'h1, 5'(i), 5'(32 - i));
    end
    @(negedge clk);
    RegWrite_MEM_WB = 1'b1;
    MemToReg_MEM_WB = 1'b0;
    RW_MEM_WB       = 5'd4;
    ALU_OUT_MEM_WB  = 32'hCAFE_0004;
    RA              = 5'd4;
    RB              = 5'd9;
    #1;
    check_outputs("pre_rst");
    #1;
    Reset_L = 1'b0;
    ref_reset();
    #1;
    check_outputs("in_rst");
    check("in_rst.r9", BusB, 32'h0);
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      RA = 5'(i);
      RB = 5'(31 - i);
      #1;
      check_outputs("rst_sweep");
    end
    @(negedge clk);
    RegWrite_MEM_WB = 1'b0;
    Reset_L = 1'b1;
    RA = 5'd4;
    RB = 5'd9;
    #1;
    check_outputs("post_rst");
    check("post_rst.r4", BusA, 32'h0);

    // first commit after reset release
    drive("post_wr", 1'b1, 1'b1, 5'd4, 32'h0BAD_F00D, 32'h0, 5'd2, 5'd3);
    drive("post_rd", 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd4, 5'd0);
    check("post_rd.r4", BusA, 32'h0BAD_F00D);
    check("post_rd.cnt", WB_Count, 32'd1);

    // final sweep of the whole array
    for (int i = 0; i < 32; i += 2) begin
      drive("sweep", 1'b0, 1'b0, 5'($urandom_range(0, 31)), $urandom, $urandom,
            5'(i), 5'(i + 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
